// File: rtl/led_pattern_gen_if.sv
// Bus bundle for led_pattern_gen.
//   en   : global run enable
//   sel  : per-channel mode, channel i at sel[3*i+:3]
//   led  : registered patterns, channel i at led[LED_W*i+:LED_W]
//   step : one-cycle pulse the cycle after each pattern advance
// master = driver of en/sel, slave = the pattern generator.
interface led_pattern_gen_if #(
  parameter int NCH   = 3,
  parameter int LED_W = 8
);
  logic                 en;
  logic [3*NCH-1:0]     sel;
  logic [LED_W*NCH-1:0] led;
  logic                 step;

  modport master (output en, sel, input  led, step);
  modport slave  (input  en, sel, output led, step);
endinterface

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator.
// A shared prescaler produces a tick every DIV enabled cycles; each channel
// advances its own pattern on that tick according to its mode.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : led_pattern_gen_if.slave (en, sel in; led, step out)

// One LED channel: mode register, pattern register, bounce direction.
module led_chan #(
  parameter int LED_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [2:0]       sel,
  output logic [LED_W-1:0] p
);
  logic [2:0]       sel_q, sel_d;
  logic [LED_W-1:0] p_q, p_d;
  logic             dir_q, dir_d;   // 0 = toward MSB, 1 = toward bit0

  always_comb begin
    sel_d = sel_q;
    p_d   = p_q;
    dir_d = dir_q;
    // A mode change reloads immediately, even on a tick edge or with en low.
    if (sel != sel_q) begin
      sel_d = sel;
      dir_d = 1'b0;
      case (sel)
        3'd1, 3'd3:       p_d = LED_W'(1);
        3'd2:             p_d = {1'b1, {(LED_W-1){1'b0}}};
        3'd0, 3'd4, 3'd5: p_d = '0;
        default:          p_d = '1;
      endcase
    end else if (tick) begin
      case (sel_q)
        3'd1: p_d = {p_q[LED_W-2:0], p_q[LED_W-1]};
        3'd2: p_d = {p_q[0], p_q[LED_W-1:1]};
        3'd3: begin
          // Turn around on the end LED so the end value is not repeated.
          if (!dir_q && p_q[LED_W-1]) begin
            dir_d = 1'b1;
            p_d   = p_q >> 1;
          end else if (dir_q && p_q[0]) begin
            dir_d = 1'b0;
            p_d   = p_q << 1;
          end else begin
            p_d   = dir_q ? (p_q >> 1) : (p_q << 1);
          end
        end
        3'd4: p_d = ~p_q;
        3'd5: p_d = (&p_q) ? '0 : {p_q[LED_W-2:0], 1'b1};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= '0;
      p_q   <= '0;
      dir_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
      p_q   <= p_d;
      dir_q <= dir_d;
    end
  end

  assign p = p_q;
endmodule

module led_pattern_gen #(
  parameter int NCH   = 3,
  parameter int LED_W = 8,
  parameter int DIV   = 4,
  parameter int DIV_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  led_pattern_gen_if.slave   bus
);
  localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(DIV-1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;
  logic             tick;
  logic [NCH-1:0][LED_W-1:0] p_arr;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (bus.en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    step_d = tick;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      step_q <= step_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    led_chan #(.LED_W(LED_W)) u_chan (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .sel  (bus.sel[3*g +: 3]),
      .p    (p_arr[g])
    );
  end

  assign bus.led  = p_arr;
  assign bus.step = step_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen (NCH=3, LED_W=8, DIV=4).
module tb_led_pattern_gen;
  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  led_pattern_gen_if #(.NCH(3), .LED_W(8)) bus ();

  led_pattern_gen #(.NCH(3), .LED_W(8), .DIV(4), .DIV_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] bounce_tbl [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
  logic [7:0] fill_tbl   [10] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                                  8'hFF, 8'h00, 8'h01};
  logic [23:0] blink_tbl [4]  = '{24'hFF40FF, 24'hFF2000, 24'hFF10FF, 24'hFF0800};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic edge_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset for one edge, apply sel, then take the first post-release edge.
  task automatic do_reset(input logic [8:0] s);
    rst = 1'b1;
    bus.en = 1'b1;
    edge_n(1);
    rst = 1'b0;
    bus.sel = s;
    edge_n(1);
  endtask

  initial begin
    rst     = 1'b1;
    bus.en  = 1'b1;
    bus.sel = {3'd2, 3'd1, 3'd0};
    edge_n(2);
    chk("rst_led",  32'(bus.led),  32'h0);
    chk("rst_step", 32'(bus.step), 32'h0);

    rst = 1'b0;
    edge_n(1);  chk("e1_led",  32'(bus.led), 32'h800100);
    chk("e1_step", 32'(bus.step), 32'h0);
    edge_n(2);  chk("e3_hold", 32'(bus.led), 32'h800100);
    chk("e3_step", 32'(bus.step), 32'h0);
    edge_n(1);  chk("e4_led",  32'(bus.led), 32'h400200);
    chk("e4_step", 32'(bus.step), 32'h1);
    edge_n(1);  chk("e5_step", 32'(bus.step), 32'h0);
    edge_n(3);  chk("e8_led",  32'(bus.led), 32'h200400);
    edge_n(20); chk("e28_led", 32'(bus.led), 32'h018000);
    edge_n(4);  chk("e32_led", 32'(bus.led), 32'h800100);

    // ch1 mode change lands on the tick edge 36
    edge_n(3);
    bus.sel = {3'd2, 3'd2, 3'd0};
    edge_n(1);  chk("reload_tick", 32'(bus.led), 32'h408000);
    edge_n(4);  chk("after_reload", 32'(bus.led), 32'h204000);

    // en low from edge 43 to 52; cnt held at 2
    edge_n(2);
    bus.en = 1'b0;
    edge_n(5);  chk("frz_led",  32'(bus.led),  32'h204000);
    chk("frz_step", 32'(bus.step), 32'h0);
    bus.sel = {3'd2, 3'd2, 3'd1};
    edge_n(1);  chk("frz_reload", 32'(bus.led), 32'h204001);
    edge_n(4);  chk("frz_led2",  32'(bus.led),  32'h204001);
    chk("frz_step2", 32'(bus.step), 32'h0);
    bus.en = 1'b1;
    edge_n(1);  chk("resume_hold", 32'(bus.led), 32'h204001);
    chk("resume_step0", 32'(bus.step), 32'h0);
    edge_n(1);  chk("resume_led", 32'(bus.led), 32'h102002);
    chk("resume_step1", 32'(bus.step), 32'h1);

    // one-edge reset mid-run, then the power-on sequence again
    rst = 1'b1;
    bus.sel = {3'd2, 3'd1, 3'd0};
    edge_n(1);  chk("mid_rst_led",  32'(bus.led),  32'h0);
    chk("mid_rst_step", 32'(bus.step), 32'h0);
    rst = 1'b0;
    edge_n(1);  chk("rr_e1",  32'(bus.led), 32'h800100);
    edge_n(3);  chk("rr_e4",  32'(bus.led), 32'h400200);
    chk("rr_e4_step", 32'(bus.step), 32'h1);

    // BOUNCE on ch0
    do_reset({3'd0, 3'd0, 3'd3});
    chk("bnc_init", 32'(bus.led[7:0]), 32'h01);
    for (int i = 0; i < 15; i++) begin
      edge_n(i == 0 ? 3 : 4);
      chk($sformatf("bnc_%0d", i), 32'(bus.led[7:0]), 32'(bounce_tbl[i]));
    end

    // FILL on ch0, ON (6) on ch1
    do_reset({3'd0, 3'd6, 3'd5});
    chk("fill_init", 32'(bus.led[15:0]), 32'hFF00);
    for (int i = 0; i < 10; i++) begin
      edge_n(i == 0 ? 3 : 4);
      chk($sformatf("fill_%0d", i), 32'(bus.led[15:0]), 32'({8'hFF, fill_tbl[i]}));
    end

    // BLINK on ch0, ROTR on ch1, ON (7) on ch2
    do_reset({3'd7, 3'd2, 3'd4});
    chk("blk_init", 32'(bus.led), 32'hFF8000);
    for (int i = 0; i < 4; i++) begin
      edge_n(i == 0 ? 3 : 4);
      chk($sformatf("blk_%0d", i), 32'(bus.led), 32'(blink_tbl[i]));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
